systolic_array_sequencer: RTL and testbench

- Control and sequencing block for a SIZE x SIZE systolic array of SystolicPE-style processing elements (multiply-accumulate, enable-gated, x moves east, w moves south).
- Accepts a job descriptor (inner dimension K), clears the array, and streams K beats of x and w vectors onto the array edges with diagonal skew.
- After the last beat it drains the pipeline and signals when all SIZE*SIZE accumulated sums are final.
- Sits between the DMA/stream front end and the array, and owns the array's shared enable and clear.

---
 rtl/systolic_array_sequencer.sv | 132 +++++++++++++
 tb/tb_systolic_array_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_sequencer.sv
// Job sequencer for a SIZE x SIZE systolic array: clears the array, streams K skewed
// x/w beats onto its west/north edges, drains the pipeline and reports completion.
module systolic_array_sequencer #(
    parameter int NBITS = 16,
    parameter int SIZE  = 4,
    parameter int KBITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_val,
    output logic                  start_rdy,
    input  logic [KBITS-1:0]      k_len,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic [SIZE*NBITS-1:0] x_vec,
    input  logic [SIZE*NBITS-1:0] w_vec,
    output logic [SIZE*NBITS-1:0] x_edge,
    output logic [SIZE*NBITS-1:0] w_edge,
    output logic                  arr_en,
    output logic                  arr_clr,
    output logic                  done_val,
    input  logic                  done_rdy,
    output logic                  busy
);

    localparam int DW = $clog2(2 * SIZE);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * (SIZE - 1) - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [KBITS-1:0] k_q;
    logic [KBITS-1:0] beat_cnt;
    logic [DW-1:0]    drain_cnt;
    logic             fire_in;
    logic             shift;

    assign fire_in   = in_val && (state == S_FEED);
    assign shift     = fire_in || (state == S_DRAIN);
    assign start_rdy = (state == S_IDLE);
    assign in_rdy    = (state == S_FEED);
    assign arr_en    = shift;
    assign arr_clr   = (state == S_CLEAR);
    assign done_val  = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    // Counters only ever compare for equality, so k = 2^KBITS-1 needs no extra bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            k_q       <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_val) begin
                        k_q   <= k_len;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    beat_cnt  <= '0;
                    drain_cnt <= '0;
                    state     <= (k_q == '0) ? S_DONE : S_FEED;
                end
                S_FEED: begin
                    if (in_val) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == k_q - 1'b1) begin
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == DRAIN_LAST)
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (done_rdy)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign x_edge[0 +: NBITS] = fire_in ? x_vec[0 +: NBITS] : '0;
    assign w_edge[0 +: NBITS] = fire_in ? w_vec[0 +: NBITS] : '0;

    // Lane i is delayed by an i-deep chain; zeros are shifted in while draining.
    for (genvar i = 1; i < SIZE; i++) begin : g_lane
        logic [NBITS-1:0] x_chain [i];
        logic [NBITS-1:0] w_chain [i];
        logic [NBITS-1:0] x_head;
        logic [NBITS-1:0] w_head;

        assign x_head = fire_in ? x_vec[i*NBITS +: NBITS] : '0;
        assign w_head = fire_in ? w_vec[i*NBITS +: NBITS] : '0;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s < i; s++) begin
                    x_chain[s] <= '0;
                    w_chain[s] <= '0;
                end
            end else if (state == S_CLEAR) begin
                for (int s = 0; s < i; s++) begin
                    x_chain[s] <= '0;
                    w_chain[s] <= '0;
                end
            end else if (shift) begin
                x_chain[0] <= x_head;
                w_chain[0] <= w_head;
                for (int s = 1; s < i; s++) begin
                    x_chain[s] <= x_chain[s-1];
                    w_chain[s] <= w_chain[s-1];
                end
            end
        end

        assign x_edge[i*NBITS +: NBITS] = x_chain[i-1];
        assign w_edge[i*NBITS +: NBITS] = w_chain[i-1];
    end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Scoreboard bench: random jobs drive the sequencer, a behavioural PE grid consumes its
// edges, and edge streams plus final sums are checked against plain matrix arithmetic.
module tb_systolic_array_sequencer;

    localparam int NBITS = 16;
    localparam int SIZE  = 4;
    localparam int KBITS = 8;
    localparam int W     = SIZE * NBITS;
    localparam int DRAIN = 2 * (SIZE - 1);
    localparam int MAXK  = 256;

    logic             clk;
    logic             rst;
    logic             start_val;
    logic             start_rdy;
    logic [KBITS-1:0] k_len;
    logic             in_val;
    logic             in_rdy;
    logic [W-1:0]     x_vec;
    logic [W-1:0]     w_vec;
    logic [W-1:0]     x_edge;
    logic [W-1:0]     w_edge;
    logic             arr_en;
    logic             arr_clr;
    logic             done_val;
    logic             done_rdy;
    logic             busy;

    systolic_array_sequencer #(.NBITS(NBITS), .SIZE(SIZE), .KBITS(KBITS)) dut (
        .clk(clk), .rst(rst), .start_val(start_val), .start_rdy(start_rdy), .k_len(k_len),
        .in_val(in_val), .in_rdy(in_rdy), .x_vec(x_vec), .w_vec(w_vec),
        .x_edge(x_edge), .w_edge(w_edge), .arr_en(arr_en), .arr_clr(arr_clr),
        .done_val(done_val), .done_rdy(done_rdy), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_x_q [$];
    logic [W-1:0] exp_w_q [$];
    int           exp_sum_q [$];
    int           exp_en_q [$];
    int           exp_lat_q [$];

    int xm [MAXK][SIZE];
    int wm [MAXK][SIZE];
    int stall_n [MAXK];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_start_rdy"}, 64'(start_rdy), 64'd1);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_arr_en"},    64'(arr_en),    64'd0);
        check({tag, "_in_rdy"},    64'(in_rdy),    64'd0);
        check({tag, "_done_val"},  64'(done_val),  64'd0);
        check({tag, "_x_edge"},    64'(x_edge),    64'd0);
        check({tag, "_w_edge"},    64'(w_edge),    64'd0);
    endtask

    // Behavioural PE grid fed by the DUT edges, plus the scoreboard consumer.
    int acc [SIZE][SIZE];
    int xr  [SIZE][SIZE];
    int wr  [SIZE][SIZE];
    int en_cnt, cyc, clr_cyc;
    bit prev_done;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++) begin
                    acc[i][j] = 0; xr[i][j] = 0; wr[i][j] = 0;
                end
            en_cnt = 0; prev_done = 1'b0;
        end else begin
            cyc++;
            if (arr_clr) begin
                check("clr_en_low", 64'(arr_en), 64'd0);
                for (int i = 0; i < SIZE; i++)
                    for (int j = 0; j < SIZE; j++) begin
                        acc[i][j] = 0; xr[i][j] = 0; wr[i][j] = 0;
                    end
                en_cnt = 0;
                clr_cyc = cyc;
            end else if (arr_en) begin
                int nx [SIZE][SIZE];
                int nw [SIZE][SIZE];
                en_cnt++;
                if (exp_x_q.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL edge_unexpected: got arr_en=1 expected no enable");
                end else begin
                    check("x_edge", x_edge, exp_x_q.pop_front());
                    check("w_edge", w_edge, exp_w_q.pop_front());
                end
                for (int i = 0; i < SIZE; i++)
                    for (int j = 0; j < SIZE; j++) begin
                        nx[i][j] = (j == 0) ? int'(x_edge[i*NBITS +: NBITS]) : xr[i][j-1];
                        nw[i][j] = (i == 0) ? int'(w_edge[j*NBITS +: NBITS]) : wr[i-1][j];
                    end
                for (int i = 0; i < SIZE; i++)
                    for (int j = 0; j < SIZE; j++) begin
                        acc[i][j] += nx[i][j] * nw[i][j];
                        xr[i][j] = nx[i][j];
                        wr[i][j] = nw[i][j];
                    end
            end
            if (done_val) check("done_en_low", 64'(arr_en), 64'd0);
            if (done_val && !prev_done) begin
                if (exp_en_q.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL done_unexpected: got done_val=1 expected no job");
                end else begin
                    check("en_count", 64'(en_cnt), 64'(exp_en_q.pop_front()));
                    check("latency", 64'(cyc - clr_cyc), 64'(exp_lat_q.pop_front()));
                    for (int i = 0; i < SIZE; i++)
                        for (int j = 0; j < SIZE; j++)
                            check($sformatf("sum_%0d_%0d", i, j), 64'(acc[i][j]),
                                  64'(exp_sum_q.pop_front()));
                end
            end
            prev_done = done_val;
        end
    end

    // Issues one job; abort_at >= 0 asserts reset after that many beats.
    task automatic applyStimulus(input int k, input bit stalls, input int hold,
                                 input int abort_at, input bit directed);
        int guard;
        int stall_total;
        int n_en;
        bit fired;
        logic [W-1:0] xv, wv;

        stall_total = 0;
        for (int t = 0; t < k; t++) begin
            for (int i = 0; i < SIZE; i++) begin
                xm[t][i] = $urandom_range(0, 255);
                wm[t][i] = $urandom_range(0, 255);
            end
            stall_n[t] = (stalls && t > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            stall_total += stall_n[t];
        end
        if (directed) begin
            xm[0][0] = 256; xm[0][1] = 512; wm[0][0] = 768; wm[0][1] = 1024;
        end

        n_en = (k == 0) ? 0 : k + DRAIN;
        for (int n = 0; n < n_en; n++) begin
            xv = '0; wv = '0;
            for (int i = 0; i < SIZE; i++)
                if (n - i >= 0 && n - i < k) begin
                    xv[i*NBITS +: NBITS] = NBITS'(xm[n-i][i]);
                    wv[i*NBITS +: NBITS] = NBITS'(wm[n-i][i]);
                end
            exp_x_q.push_back(xv);
            exp_w_q.push_back(wv);
        end
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                int s = 0;
                for (int t = 0; t < k; t++) s += xm[t][i] * wm[t][j];
                exp_sum_q.push_back(s);
            end
        exp_en_q.push_back(n_en);
        exp_lat_q.push_back((k == 0) ? 1 : 1 + k + stall_total + DRAIN);

        start_val = 1'b1;
        k_len     = KBITS'(k);
        @(negedge clk);
        check("start_rdy", 64'(start_rdy), 64'd1);
        step();
        start_val = 1'b0;
        k_len     = KBITS'($urandom);
        @(negedge clk);
        check("arr_clr", 64'(arr_clr), 64'd1);
        step();

        for (int t = 0; t < k; t++) begin
            if (t == abort_at) begin
                #2;
                rst = 1'b0;
                exp_x_q.delete(); exp_w_q.delete();
                exp_sum_q.delete(); exp_en_q.delete(); exp_lat_q.delete();
                #1;
                check_idle("abort");
                step();
                rst    = 1'b1;
                in_val = 1'b0;
                return;
            end
            if (stall_n[t] > 0) begin
                in_val = 1'b0;
                repeat (stall_n[t]) step();
            end
            for (int i = 0; i < SIZE; i++) begin
                x_vec[i*NBITS +: NBITS] = NBITS'(xm[t][i]);
                w_vec[i*NBITS +: NBITS] = NBITS'(wm[t][i]);
            end
            in_val = 1'b1;
            guard  = 0;
            do begin
                @(negedge clk);
                fired = in_rdy;
                step();
                guard++;
            end while (!fired && guard < 20);
            if (!fired) begin
                total++; bad++;
                $display("[TB] FAIL beat_timeout: got in_rdy=0 expected beat %0d accepted", t);
                in_val = 1'b0;
                return;
            end
        end

        in_val = 1'($urandom_range(0, 1));
        x_vec  = {$urandom, $urandom};
        w_vec  = {$urandom, $urandom};

        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!done_val && guard < 600);
        if (!done_val) begin
            total++; bad++;
            $display("[TB] FAIL done_timeout: got done_val=0 expected 1");
            in_val = 1'b0;
            return;
        end

        start_val = 1'b1;
        for (int h = 0; h < hold; h++) begin
            check("hold_done_val",  64'(done_val),  64'd1);
            check("hold_start_rdy", 64'(start_rdy), 64'd0);
            check("hold_in_rdy",    64'(in_rdy),    64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        start_val = 1'b0;
        in_val    = 1'b0;
        done_rdy  = 1'b1;
        step();
        done_rdy = 1'b0;
        @(negedge clk);
        check("after_done_busy",      64'(busy),      64'd0);
        check("after_done_start_rdy", 64'(start_rdy), 64'd1);
        step();
    endtask

    task automatic checkOutput();
        repeat (DRAIN + 4) @(negedge clk);
        check("leftover_edges", 64'(exp_x_q.size()), 64'd0);
        check("leftover_jobs",  64'(exp_en_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; start_val = 1'b1; k_len = '0; in_val = 1'b0;
        x_vec = '0; w_vec = '0; done_rdy = 1'b0;
        cyc = 0; clr_cyc = 0;
        repeat (3) begin
            @(negedge clk);
            check_idle("reset");
        end
        step();
        rst = 1'b1;

        applyStimulus(1, 1'b0, 0, -1, 1'b1);
        applyStimulus(3, 1'b1, 1, -1, 1'b0);
        applyStimulus(0, 1'b0, 5, -1, 1'b0);
        applyStimulus(4, 1'b0, 0, 2, 1'b0);
        applyStimulus(1, 1'b0, 0, -1, 1'b0);
        for (int r = 0; r < 6; r++)
            applyStimulus($urandom_range(1, 20), 1'b1, $urandom_range(0, 3), -1, 1'b0);
        applyStimulus(255, 1'b0, 2, -1, 1'b0);
        applyStimulus(2, 1'b1, 0, -1, 1'b0);
        checkOutput();
    end

endmodule
